miriscv_mdu: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in data width. It sits beside the combinational ALU in the execute stage. It accepts one request at a time, runs a radix-2 shift-add / restoring-divide loop over XLEN cycles, and returns a registered result with a one-cycle valid pulse. The core stalls on `busy_o`.

---
 rtl/miriscv_mdu_pkg.sv | 31 +++
 rtl/miriscv_mdu.sv | 172 +++++++++++++++++
 tb/tb_miriscv_mdu.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/miriscv_mdu_pkg.sv
// Shared RV32M multiply/divide op codes and MDU state encoding.
package miriscv_mdu_pkg;

    localparam int unsigned MDU_OP_WIDTH = 3;

    typedef enum logic [MDU_OP_WIDTH-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_DONE
    } mdu_state_e;

    function automatic logic op_a_signed(mdu_op_e op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_b_signed(mdu_op_e op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/miriscv_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on unsigned magnitudes, sharing one accumulator, counter and adder.
module miriscv_mdu
    import miriscv_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    req_i,
    input  logic [MDU_OP_WIDTH-1:0] operator_i,
    input  logic [XLEN-1:0]         operand_a_i,
    input  logic [XLEN-1:0]         operand_b_i,
    input  logic                    flush_i,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic [XLEN-1:0]         result_o
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN + 1;
    localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e          state_q, state_d;
    mdu_op_e             op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic                busy_q, busy_d, valid_q, valid_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    mdu_op_e             op_in;
    logic                is_div, step_bit;
    logic [XLEN:0]       rem_shift;
    logic [AW-1:0]       add_a, add_b, sum;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot, rem, fix_res;

    assign op_in = mdu_op_e'(operator_i);

    // Multiply: acc = 2*acc + (b[cnt] ? a : 0), MSB-first. Divide: acc = {rem, quot}.
    always_comb begin
        is_div    = op_q inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
        step_bit  = is_div ? a_q[cnt_q] : b_q[cnt_q];
        rem_shift = {acc_q[2*XLEN-1:XLEN], step_bit};
        if (is_div) begin
            add_a = {{XLEN{1'b0}}, rem_shift};
            add_b = {{(XLEN+1){1'b0}}, b_q};
        end else begin
            add_a = {1'b0, acc_q[2*XLEN-2:0], 1'b0};
            add_b = {{(XLEN+1){1'b0}}, (step_bit ? a_q : '0)};
        end
        sum = add_a + (add_b ^ {AW{is_div}}) + AW'(is_div);

        prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            MDU_MUL:                        fix_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              fix_res = quot;
            default:                        fix_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        result_d = result_q;
        valid_d  = 1'b0;
        unique case (state_q)
            MDU_IDLE: begin
                busy_d = 1'b0;
                if (req_i && !busy_q && !flush_i) begin
                    op_d    = op_in;
                    sa_d    = op_a_signed(op_in) & operand_a_i[XLEN-1];
                    sb_d    = op_b_signed(op_in) & operand_b_i[XLEN-1];
                    a_d     = sa_d ? -operand_a_i : operand_a_i;
                    b_d     = sb_d ? -operand_b_i : operand_b_i;
                    acc_d   = '0;
                    cnt_d   = CW'(XLEN - 1);
                    busy_d  = 1'b1;
                    state_d = MDU_CALC;
                    // Fast paths preload {rem, quot} with signs cleared so DONE passes them through.
                    if (op_in inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU}) begin
                        if (operand_b_i == '0) begin
                            acc_d   = {operand_a_i, {XLEN{1'b1}}};
                            sa_d    = 1'b0;
                            sb_d    = 1'b0;
                            state_d = MDU_DONE;
                        end else if (op_in inside {MDU_DIV, MDU_REM} &&
                                     operand_a_i == MIN_SIGNED && operand_b_i == '1) begin
                            acc_d   = {{XLEN{1'b0}}, MIN_SIGNED};
                            sa_d    = 1'b0;
                            sb_d    = 1'b0;
                            state_d = MDU_DONE;
                        end
                    end
                end
            end
            MDU_CALC: begin
                if (flush_i) begin
                    state_d = MDU_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (!is_div) begin
                        acc_d = sum[2*XLEN-1:0];
                    end else if (!sum[AW-1]) begin
                        acc_d = {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = MDU_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
                if (flush_i) begin
                    busy_d = 1'b0;
                end else begin
                    result_d = fix_res;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= MDU_IDLE;
            op_q     <= MDU_MUL;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_miriscv_mdu.sv
// Directed and small randomised bench for miriscv_mdu at XLEN=32.
module tb_miriscv_mdu;

    localparam int unsigned XLEN = 32;

    logic             clk, arstn, req, flush;
    logic [2:0]       op;
    logic [XLEN-1:0]  a, b, result;
    logic             busy, valid;
    int unsigned      n_tests, n_fail;

    miriscv_mdu #(.XLEN(XLEN)) dut (
        .clk_i       (clk),
        .arstn_i     (arstn),
        .req_i       (req),
        .operator_i  (op),
        .operand_a_i (a),
        .operand_b_i (b),
        .flush_i     (flush),
        .busy_o      (busy),
        .valid_o     (valid),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int          q;
        case (o)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
            3'd2: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                q = $signed(x) / $signed(y);
                return q;
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                q = $signed(x) % $signed(y);
                return q;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int unsigned exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int unsigned exp_lat);
        int unsigned lat;
        logic        busy_ok;
        op = o; a = x; b = y; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        // Scramble inputs after acceptance: the unit must use its captured copies.
        a = ~x; b = ~y; op = o ^ 3'd1;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_result"}, result, exp);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
    endtask

    initial begin
        logic [2:0]  cur_op;
        logic [31:0] cur_a, cur_b, exp_r;
        int unsigned exp_l, w;

        n_tests = 0;
        n_fail  = 0;
        arstn = 1'b0; req = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_result", result, 32'd0);
        arstn = 1'b1;
        @(posedge clk); #1;

        do_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        do_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        do_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        do_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        do_op("divu",   3'd5, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 33);
        do_op("remu",   3'd7, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 33);

        // Flush a DIVU ten cycles in; result must stay at the REMU value.
        op = 3'd5; a = 32'd100; b = 32'd7; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_result", result, 32'h0000000F);
        do_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        op = 3'd0; a = 32'd9; b = 32'd9; req = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; flush = 1'b0;
        check("idle_flush_blocks_req", 32'(busy), 32'd0);

        // Asynchronous reset mid-CALC clears everything immediately.
        op = 3'd0; a = 32'd5; b = 32'd6; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 arstn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_result", result, 32'd0);
        #2 arstn = 1'b1;
        @(posedge clk); #1;

        do_op("fast_div0",  3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op("fast_remu0", 3'd7, 32'd5,        32'd0,        32'd5,        1);
        do_op("fast_divov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("fast_remov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // req held high: each op accepted only once busy drops; next operands driven right after acceptance.
        cur_op = 3'($urandom_range(7, 0)); cur_a = $urandom; cur_b = $urandom;
        op = cur_op; a = cur_a; b = cur_b; req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (!busy && w < 100) begin @(posedge clk); #1; w++; end
            check("b2b_accept_wait", w, 32'd1);
            exp_r = ref_mdu(cur_op, cur_a, cur_b);
            exp_l = exp_latency(cur_op, cur_a, cur_b);
            if (k < 2) begin
                cur_op = 3'($urandom_range(7, 0)); cur_a = $urandom; cur_b = $urandom;
                op = cur_op; a = cur_a; b = cur_b;
            end else begin
                req = 1'b0;
            end
            w = 0;
            while (!valid && w < 100) begin @(posedge clk); #1; w++; end
            check("b2b_result", result, exp_r);
            check("b2b_latency", w, exp_l);
            check("b2b_busy_in_valid", 32'(busy), 32'd1);
            @(posedge clk); #1;
            check("b2b_busy_after", 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
